// File: rtl/uart_tx_fifo_if.sv
// Byte-stream side of the UART transmitter: valid/ready push port plus line and status outputs.
interface uart_tx_fifo_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
);
  logic [DATA_BITS-1:0]        tx_data;
  logic                        tx_valid;
  logic                        tx_ready;
  logic                        txd;
  logic                        tx_busy;
  logic [$clog2(FIFO_DEPTH):0] fifo_level;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, txd, tx_busy, fifo_level
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, txd, tx_busy, fifo_level
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a FIFO; queued words leave back-to-back with the next
// start bit directly following the last stop bit.
module uart_tx_fifo #(
  parameter int CLK_DIV    = 5208,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int MSB_FIRST  = 0,
  parameter int FIFO_DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  uart_tx_fifo_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(DATA_BITS);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [LVL_W-1:0]     r_level;

  state_t               r_state;
  logic                 r_txd;
  logic                 r_busy;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;
  logic [CNT_W-1:0]     r_baud;
  logic [BIT_W-1:0]     r_bit_cnt;
  logic                 r_stop_cnt;

  logic                 w_ready;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_has_word;
  logic                 w_bit_end;
  logic                 w_last_stop;
  logic                 w_next_bit;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic [DATA_BITS-1:0] w_head;

  function automatic logic f_parity(input logic [DATA_BITS-1:0] word);
    return (PARITY == 1) ? ~(^word) : ^word;
  endfunction

  assign w_ready     = (r_level != LVL_W'(FIFO_DEPTH));
  assign w_push      = bus.tx_valid & w_ready;
  assign w_has_word  = (r_level != '0);
  assign w_bit_end   = (r_baud == CNT_W'(CLK_DIV - 1));
  assign w_last_stop = (r_stop_cnt == 1'(STOP_BITS - 1));
  assign w_head      = r_mem[r_rd_ptr];
  // Pop either from idle or exactly on the final stop-bit boundary, so frames abut.
  assign w_pop       = w_has_word &
                       ((r_state == S_IDLE) |
                        ((r_state == S_STOP) & w_bit_end & w_last_stop));

  assign w_next_bit  = (MSB_FIRST != 0) ? r_shift[DATA_BITS-1] : r_shift[0];
  assign w_shift_nxt = (MSB_FIRST != 0) ? (r_shift << 1) : (r_shift >> 1);

  assign bus.tx_ready   = w_ready;
  assign bus.txd        = r_txd;
  assign bus.tx_busy    = r_busy;
  assign bus.fifo_level = r_level;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.tx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_txd      <= 1'b1;
      r_busy     <= 1'b0;
      r_shift    <= '0;
      r_par      <= 1'b0;
      r_baud     <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
    end else begin
      // Every frame load happens in idle or on a bit boundary, so this also zeroes it on load.
      r_baud <= ((r_state == S_IDLE) || w_bit_end) ? '0 : r_baud + CNT_W'(1);

      case (r_state)
        S_IDLE: begin
          r_txd <= 1'b1;
          if (w_pop) begin
            r_shift <= w_head;
            r_par   <= f_parity(w_head);
            r_txd   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_txd     <= w_next_bit;
            r_shift   <= w_shift_nxt;
            r_bit_cnt <= '0;
            r_state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            if (r_bit_cnt == BIT_W'(DATA_BITS - 1)) begin
              if (PARITY != 0) begin
                r_txd   <= r_par;
                r_state <= S_PARITY;
              end else begin
                r_txd      <= 1'b1;
                r_stop_cnt <= 1'b0;
                r_state    <= S_STOP;
              end
            end else begin
              r_txd     <= w_next_bit;
              r_shift   <= w_shift_nxt;
              r_bit_cnt <= r_bit_cnt + BIT_W'(1);
            end
          end
        end
        S_PARITY: begin
          if (w_bit_end) begin
            r_txd      <= 1'b1;
            r_stop_cnt <= 1'b0;
            r_state    <= S_STOP;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            if (w_last_stop) begin
              if (w_pop) begin
                r_shift <= w_head;
                r_par   <= f_parity(w_head);
                r_txd   <= 1'b0;
                r_state <= S_START;
              end else begin
                r_txd   <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= S_IDLE;
              end
            end else begin
              r_stop_cnt <= r_stop_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_txd   <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench: four frame formats driven from a vector table, plus FIFO-full,
// push/pop-at-boundary and mid-frame reset sequences on the depth-4 instance.
module tb_uart_tx_fifo;
  localparam int DIV = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [8:0] r_data  [4];
  logic       r_valid [4];
  logic       w_txd   [4];
  logic       w_busy  [4];
  logic       w_ready [4];
  logic [4:0] w_level [4];

  int n_checks = 0;
  int n_errors = 0;

  // Instance 0: 8N1 LSB first, depth 4. 1: 7E2. 2: 7O2. 3: 8N1 MSB first.
  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4))  u0 ();
  uart_tx_fifo_if #(.DATA_BITS(7), .FIFO_DEPTH(16)) u1 ();
  uart_tx_fifo_if #(.DATA_BITS(7), .FIFO_DEPTH(16)) u2 ();
  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) u3 ();

  uart_tx_fifo #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .MSB_FIRST(0), .FIFO_DEPTH(4))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(u0.slave));
  uart_tx_fifo #(.CLK_DIV(DIV), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .MSB_FIRST(0), .FIFO_DEPTH(16))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(u1.slave));
  uart_tx_fifo #(.CLK_DIV(DIV), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .MSB_FIRST(0), .FIFO_DEPTH(16))
    dut2 (.clk(clk), .rst_n(rst_n), .bus(u2.slave));
  uart_tx_fifo #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .MSB_FIRST(1), .FIFO_DEPTH(16))
    dut3 (.clk(clk), .rst_n(rst_n), .bus(u3.slave));

  assign u0.tx_data = r_data[0][7:0];
  assign u1.tx_data = r_data[1][6:0];
  assign u2.tx_data = r_data[2][6:0];
  assign u3.tx_data = r_data[3][7:0];
  assign u0.tx_valid = r_valid[0];
  assign u1.tx_valid = r_valid[1];
  assign u2.tx_valid = r_valid[2];
  assign u3.tx_valid = r_valid[3];
  assign w_txd[0] = u0.txd;   assign w_busy[0] = u0.tx_busy;
  assign w_txd[1] = u1.txd;   assign w_busy[1] = u1.tx_busy;
  assign w_txd[2] = u2.txd;   assign w_busy[2] = u2.tx_busy;
  assign w_txd[3] = u3.txd;   assign w_busy[3] = u3.tx_busy;
  assign w_ready[0] = u0.tx_ready;
  assign w_ready[1] = u1.tx_ready;
  assign w_ready[2] = u2.tx_ready;
  assign w_ready[3] = u3.tx_ready;
  assign w_level[0] = {2'b00, u0.fifo_level};
  assign w_level[1] = u1.fifo_level;
  assign w_level[2] = u2.fifo_level;
  assign w_level[3] = u3.fifo_level;

  // Per-cycle line capture of instance 0 for the multi-frame sequences.
  logic       cap_en = 1'b0;
  logic       cap_q [$];
  logic [7:0] exp_q [$];
  always @(negedge clk) if (cap_en) cap_q.push_back(w_txd[0]);

  typedef struct {
    int         dut;
    logic [8:0] data;
    int         nbits;
    string      bits;   // expected line level per bit period, first character first
    string      name;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_idle(input int d);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (!w_busy[d] && w_level[d] == 5'd0) done = 1'b1;
    end
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_idle dut%0d: got busy, expected idle within 3000 cycles", d);
    end
  endtask

  task automatic send_vec(input vec_t v);
    int   d;
    logic ok;
    logic exp_bit;
    d = v.dut;
    wait_idle(d);
    @(negedge clk);
    r_data[d]  = v.data;
    r_valid[d] = 1'b1;
    @(negedge clk);
    r_valid[d] = 1'b0;
    check($sformatf("%s pre-start txd", v.name), 32'(w_txd[d]), 32'd1);
    check($sformatf("%s level after push", v.name), 32'(w_level[d]), 32'd1);
    for (int b = 0; b < v.nbits; b++) begin
      exp_bit = (v.bits[b] == 8'h31);
      ok = 1'b1;
      for (int c = 0; c < DIV; c++) begin
        @(negedge clk);
        if (w_txd[d] !== exp_bit || w_busy[d] !== 1'b1) ok = 1'b0;
      end
      check($sformatf("%s bit%0d (txd=%0b busy=%0b)", v.name, b, w_txd[d], w_busy[d]), 32'(ok), 32'd1);
    end
    @(negedge clk);
    check($sformatf("%s busy after frame", v.name), 32'(w_busy[d]), 32'd0);
    check($sformatf("%s txd after frame", v.name), 32'(w_txd[d]), 32'd1);
  endtask

  // Decodes back-to-back 8N1 frames from the capture; a gap shifts the grid and breaks decoding.
  task automatic decode(input string name);
    int         s;
    int         base;
    logic [7:0] byte_v;
    logic       framing;
    logic       quiet;
    s = -1;
    for (int i = 0; i < cap_q.size() && s < 0; i++) if (cap_q[i] == 1'b0) s = i;
    if (s < 0 || s + 40 * exp_q.size() > cap_q.size()) begin
      check($sformatf("%s capture length", name), 32'(cap_q.size()), 32'(40 * exp_q.size()));
      return;
    end
    for (int f = 0; f < exp_q.size(); f++) begin
      base = s + 40 * f;
      for (int j = 0; j < 8; j++) byte_v[j] = cap_q[base + 4 * (j + 1) + 2];
      framing = (cap_q[base + 2] == 1'b0) && (cap_q[base + 38] == 1'b1);
      check($sformatf("%s frame%0d data", name, f), 32'(byte_v), 32'(exp_q[f]));
      check($sformatf("%s frame%0d framing", name, f), 32'(framing), 32'd1);
    end
    quiet = 1'b1;
    for (int i = s + 40 * exp_q.size(); i < cap_q.size(); i++) if (cap_q[i] !== 1'b1) quiet = 1'b0;
    check($sformatf("%s line idle after last frame", name), 32'(quiet), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   w;
    logic rdy;
    logic saw_full;
    logic [4:0] max_lvl;
    logic quiet;

    for (int d = 0; d < 4; d++) begin
      r_data[d]  = '0;
      r_valid[d] = 1'b0;
    end

    vecs[0] = '{0, 9'h0A5, 10, "0101001011",  "8N1 A5"};
    vecs[1] = '{0, 9'h03C, 10, "0001111001",  "8N1 3C"};
    vecs[2] = '{1, 9'h053, 11, "01100101011", "7E2 53"};
    vecs[3] = '{1, 9'h07F, 11, "01111111111", "7E2 7F"};
    vecs[4] = '{2, 9'h053, 11, "01100101111", "7O2 53"};
    vecs[5] = '{3, 9'h081, 10, "0100000011",  "MSB 81"};
    vecs[6] = '{3, 9'h040, 10, "0010000001",  "MSB 40"};
    vecs[7] = '{3, 9'h053, 10, "0010100111",  "MSB 53"};

    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 4; d++) begin
      check($sformatf("reset txd dut%0d", d),   32'(w_txd[d]),   32'd1);
      check($sformatf("reset busy dut%0d", d),  32'(w_busy[d]),  32'd0);
      check($sformatf("reset level dut%0d", d), 32'(w_level[d]), 32'd0);
      check($sformatf("reset ready dut%0d", d), 32'(w_ready[d]), 32'd1);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) send_vec(vecs[i]);

    // Six words held valid into a depth-4 FIFO while the line is busy.
    wait_idle(0);
    cap_q.delete();
    cap_en   = 1'b1;
    saw_full = 1'b0;
    max_lvl  = '0;
    w = 1;
    for (int t = 0; t < 500 && w <= 6; t++) begin
      @(negedge clk);
      r_data[0]  = 9'(w);
      r_valid[0] = 1'b1;
      if (w_level[0] > max_lvl) max_lvl = w_level[0];
      if (!w_ready[0]) saw_full = 1'b1;
      rdy = w_ready[0];
      @(posedge clk);
      if (rdy) w++;
    end
    @(negedge clk);
    r_valid[0] = 1'b0;
    check("full: words accepted", 32'(w), 32'd7);
    check("full: ready dropped", 32'(saw_full), 32'd1);
    check("full: peak level", 32'(max_lvl), 32'd4);
    wait_idle(0);
    repeat (4) @(negedge clk);
    cap_en = 1'b0;
    exp_q.delete();
    for (int i = 1; i <= 6; i++) exp_q.push_back(8'(i));
    decode("full");

    // Push coinciding with the frame-boundary pop at level 3; pointers wrap here.
    wait_idle(0);
    cap_q.delete();
    cap_en = 1'b1;
    @(negedge clk); r_data[0] = 9'h011; r_valid[0] = 1'b1;
    @(negedge clk); r_data[0] = 9'h022;
    @(negedge clk); r_data[0] = 9'h033;
    @(negedge clk); r_data[0] = 9'h044;
    @(negedge clk); r_valid[0] = 1'b0;
    repeat (37) @(negedge clk);
    check("pushpop: level before", 32'(w_level[0]), 32'd3);
    check("pushpop: ready before", 32'(w_ready[0]), 32'd1);
    r_data[0]  = 9'h055;
    r_valid[0] = 1'b1;
    @(negedge clk);
    r_valid[0] = 1'b0;
    check("pushpop: level after", 32'(w_level[0]), 32'd3);
    check("pushpop: ready after", 32'(w_ready[0]), 32'd1);
    wait_idle(0);
    repeat (4) @(negedge clk);
    cap_en = 1'b0;
    exp_q.delete();
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    exp_q.push_back(8'h44); exp_q.push_back(8'h55);
    decode("pushpop");

    // Reset in the middle of a data bit with three words still queued.
    wait_idle(0);
    @(negedge clk); r_data[0] = 9'h000; r_valid[0] = 1'b1;
    repeat (4) @(negedge clk);
    r_valid[0] = 1'b0;
    repeat (6) @(negedge clk);
    check("midreset: txd low before", 32'(w_txd[0]), 32'd0);
    check("midreset: level before", 32'(w_level[0]), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("midreset: txd", 32'(w_txd[0]), 32'd1);
    check("midreset: level", 32'(w_level[0]), 32'd0);
    check("midreset: busy", 32'(w_busy[0]), 32'd0);
    check("midreset: ready", 32'(w_ready[0]), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (w_txd[0] !== 1'b1 || w_busy[0] !== 1'b0 || w_level[0] !== 5'd0) quiet = 1'b0;
    end
    check("midreset: no resume", 32'(quiet), 32'd1);
    send_vec(vecs[1]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
